ctrl_word_sequencer: RTL
========================

Name: ctrl_word_sequencer

Overview:
Produces the 8-bit opcode words that drive the instruction decoder's four 2-to-4 decoder fields. It accepts control-action requests over a valid/ready handshake and encodes each request into per-field 2-bit codes. Encoded words are buffered in a small FIFO and presented one at a time on the opcode bus, each held for a programmable number of cycles. When no word is being issued, the bus carries the all-NOP word.

Parameters:
FIFO_DEPTH, 4, number of encoded entries buffered; power of 2, at least 2.
HOLD_W, 4, width of the per-request hold count.

Ports:
clk  input  1  single system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  a request is present.
req_ready  output  1  sequencer can accept a request; equals !full && !rst.
req_ctrl  input  12  action bits: [11:9]={rst,incr,rd_en_alu}, [8:6]={wr_en,compl_en,opcode1}, [5:3]={out_en,opcode2,rd_en_reg_bank}, [2:0]={sel,decr,opcode3}.
req_hold  input  HOLD_W  extra cycles to hold the word.
opcode_out  output  8  registered opcode; [7:6]=field1 … [1:0]=field4.
issue_strobe  output  1  one-cycle pulse on the first cycle of each new word.
busy  output  1  high when state!=IDLE or the FIFO is not empty.
err_multi  output  1  one-cycle pulse when a request is rejected.
fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Field encoding:
  - Field1: rst→11, incr→10, rd_en_alu→00, none→01 (NOP).
  - Fields 2–4: first-listed bit→11, second→10, third→01, none→00.
  - NOP_WORD = 8'h40. Field1 NOP is 01; 00 asserts rd_en_alu, so 8'h00 is never idle.
- Handshake and validation:
  - A transfer occurs when req_valid && req_ready at the clock edge.
  - If any 3-bit field has more than one bit set, the transfer completes but the request is dropped and err_multi pulses on the next cycle.
  - Otherwise {encoded word, req_hold} is pushed into the FIFO.
- FSM:
  - IDLE: opcode_out = NOP_WORD. If the FIFO is not empty: pop, load the word, set hold_cnt = hold, pulse issue_strobe, go to ISSUE.
  - ISSUE: the word is held for hold+1 cycles (hold=0 gives 1 cycle). When the hold expires:
    - next entry present: load it back-to-back with issue_strobe, stay in ISSUE;
    - FIFO empty: load NOP_WORD, go to IDLE;
    - NOP_GAP_EN defined: see Optional Feature.
  - GAP (feature only): NOP_WORD for exactly one cycle, then behave as IDLE.
- Latency: request accepted at edge N → word appears on opcode_out at edge N+1 when the FSM is IDLE.
- FIFO:
  - req_ready is low when full, with no pass-through on a simultaneous pop at full.
  - Push and pop in the same cycle when not full both occur; fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (synchronous, including mid-hold or mid-gap):
  - Next edge: opcode_out = NOP_WORD; state = IDLE; FIFO emptied; fifo_count = 0; issue_strobe, err_multi, busy = 0.
  - No request is accepted during reset.

Optional Feature:
- Macro NOP_GAP_EN.
- Defined: after each word's hold expires, exactly one NOP_WORD cycle (GAP) is inserted before the next word, even if the FIFO is non-empty.
- Undefined: words issue back-to-back; GAP state is not built.

Decomposition:
- Package ctrl_seq_pkg holds:
  - field code constants per field;
  - NOP_WORD;
  - req_ctrl bit-position constants;
  - FSM state enum {IDLE, ISSUE, GAP};
  - encode function (12-bit action vector → 8-bit word + multi-hot flag).
- One sub-module, ctrl_seq_fifo: synchronous FIFO, width 8+HOLD_W, depth FIFO_DEPTH, with full/empty/count.

Test Plan:
1. Reset, then idle → opcode_out=8'h40, req_ready=1, busy=0, fifo_count=0.
2. req_ctrl=12'b010_000_000_000, hold=0 → 8'h80 for 1 cycle with issue_strobe, then 8'h40. req_ctrl=12'b001_000_000_000 → 8'h00 for 1 cycle.
3. req_ctrl=12'b000_100_100_100, hold=2 → 8'h7F for exactly 3 cycles. A second request queued behind it issues immediately after (8'h40 gap cycle with NOP_GAP_EN).
4. req_ctrl=12'b110_000_000_001 → err_multi pulses once, fifo_count stays 0, opcode_out stays 8'h40.
5. Five requests with hold=15 while the first is issuing → fifo_count=4 and req_ready=0. The fifth is accepted only after a pop; all issue in order.
6. Assert rst during the 5th hold cycle with 2 entries queued → next edge: opcode_out=8'h40, fifo_count=0, busy=0, and no queued word ever issues.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared encodings, FSM states and the action-to-opcode encode function for ctrl_word_sequencer.
package ctrl_seq_pkg;

    localparam logic [1:0] F1_RST     = 2'b11;
    localparam logic [1:0] F1_INCR    = 2'b10;
    localparam logic [1:0] F1_RD_ALU  = 2'b00;
    localparam logic [1:0] F1_NOP     = 2'b01;

    localparam logic [1:0] FX_FIRST   = 2'b11;
    localparam logic [1:0] FX_SECOND  = 2'b10;
    localparam logic [1:0] FX_THIRD   = 2'b01;
    localparam logic [1:0] FX_NOP     = 2'b00;

    // Field1 idles at 01 because 00 would assert rd_en_alu.
    localparam logic [7:0] NOP_WORD   = 8'h40;

    localparam int CTRL_F1_MSB = 11;
    localparam int CTRL_F2_MSB = 8;
    localparam int CTRL_F3_MSB = 5;
    localparam int CTRL_F4_MSB = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    typedef struct packed {
        logic [7:0] word;
        logic       multi;
    } enc_t;

    function automatic logic multi_hot(input logic [2:0] g);
        return (g[2] & g[1]) | (g[2] & g[0]) | (g[1] & g[0]);
    endfunction

    function automatic logic [1:0] enc_f1(input logic [2:0] g);
        if (g[2])      return F1_RST;
        else if (g[1]) return F1_INCR;
        else if (g[0]) return F1_RD_ALU;
        else           return F1_NOP;
    endfunction

    function automatic logic [1:0] enc_fx(input logic [2:0] g);
        if (g[2])      return FX_FIRST;
        else if (g[1]) return FX_SECOND;
        else if (g[0]) return FX_THIRD;
        else           return FX_NOP;
    endfunction

    function automatic enc_t encode(input logic [11:0] c);
        enc_t r;
        r.word  = {enc_f1(c[CTRL_F1_MSB -: 3]), enc_fx(c[CTRL_F2_MSB -: 3]),
                   enc_fx(c[CTRL_F3_MSB -: 3]), enc_fx(c[CTRL_F4_MSB -: 3])};
        r.multi = multi_hot(c[CTRL_F1_MSB -: 3]) | multi_hot(c[CTRL_F2_MSB -: 3]) |
                  multi_hot(c[CTRL_F3_MSB -: 3]) | multi_hot(c[CTRL_F4_MSB -: 3]);
        return r;
    endfunction

endpackage

// File: rtl/ctrl_seq_fifo.sv
// Synchronous FIFO with show-ahead read so the sequencer can load an entry on the same edge it pops.
module ctrl_seq_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ctrl_word_sequencer.sv
// Encodes control-action requests into decoder opcode words, queues them and issues each for hold+1 cycles.
// Define NOP_GAP_EN to insert one NOP_WORD cycle after every issued word.
module ctrl_word_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [11:0]                   req_ctrl,
    input  logic [HOLD_W-1:0]             req_hold,
    output logic [7:0]                    opcode_out,
    output logic                          issue_strobe,
    output logic                          busy,
    output logic                          err_multi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int ENT_W = 8 + HOLD_W;

    enc_t              enc;
    logic              xfer, push, pop, take;
    logic              fifo_full, fifo_empty;
    logic [ENT_W-1:0]  fifo_dout;

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              strobe_q, strobe_d;
    logic              err_q, err_d;

    assign enc       = encode(req_ctrl);
    assign req_ready = !fifo_full && !rst;
    assign xfer      = req_valid && req_ready;
    assign push      = xfer && !enc.multi;
    assign pop       = take;

    ctrl_seq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({enc.word, req_hold}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        hold_cnt_d = hold_cnt_q;
        strobe_d   = 1'b0;
        err_d      = xfer && enc.multi;
        take       = 1'b0;
        case (state_q)
            IDLE: begin
                take     = !fifo_empty;
                opcode_d = NOP_WORD;
            end
`ifdef NOP_GAP_EN
            GAP: begin
                take     = !fifo_empty;
                opcode_d = NOP_WORD;
                state_d  = IDLE;
            end
`endif
            ISSUE: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else begin
`ifdef NOP_GAP_EN
                    state_d  = GAP;
                    opcode_d = NOP_WORD;
`else
                    take     = !fifo_empty;
                    opcode_d = NOP_WORD;
                    state_d  = IDLE;
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                opcode_d = NOP_WORD;
            end
        endcase
        // A pop always overrides the NOP defaults chosen above.
        if (take) begin
            opcode_d   = fifo_dout[ENT_W-1 -: 8];
            hold_cnt_d = fifo_dout[HOLD_W-1:0];
            strobe_d   = 1'b1;
            state_d    = ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= NOP_WORD;
            hold_cnt_q <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            hold_cnt_q <= hold_cnt_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    assign opcode_out   = opcode_q;
    assign issue_strobe = strobe_q;
    assign err_multi    = err_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
